isp_demosaic_ctrl: RTL and testbench
====================================

Name: isp_demosaic_ctrl

Overview:
- Frame sequencer and configuration controller placed directly in front of the 5x5 Bayer demosaic stage in the HDMI ISP path.
- Applies Bayer-pattern and bypass configuration only at frame boundaries through shadow registers.
- Checks incoming frame geometry against WIDTH/HEIGHT.
- After the last real line, generates FLUSH_LINES synthetic lines so the demosaic line buffer drains its final rows.

Parameters:
- WIDTH, 1280: active pixels per line.
- HEIGHT, 960: active lines per frame.
- FLUSH_LINES, 2: synthetic lines inserted after the last real line (1..4).
- HBLANK, 16: idle pclk cycles between synthetic lines and before the first one (>=2).
- CNT_W, 16: width of the frame counter.

Ports:
- pclk  input  1  pixel clock
- rst  input  1  asynchronous, active-high reset
- cfg_bayer  input  2  staged pattern (0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR)
- cfg_bypass  input  1  staged bypass request
- cfg_wr  input  1  one-cycle pulse; captures cfg_bayer/cfg_bypass into the shadow
- err_clr  input  1  one-cycle pulse; clears the sticky error flags
- in_href  input  1  sensor line valid
- in_vsync  input  1  sensor frame sync, active high
- in_de  input  1  sensor data enable
- out_href  output  1  line valid to the demosaic
- out_vsync  output  1  frame sync to the demosaic
- out_de  output  1  data enable to the demosaic
- out_flush  output  1  high while a synthetic line is driven; the downstream mux forces raw = 0
- act_bayer  output  2  Bayer pattern active for the current frame
- act_bypass  output  1  bypass setting active for the current frame
- frame_done  output  1  one-cycle pulse when a frame, including its flush, completes
- err_width  output  1  sticky: a line length differed from WIDTH
- err_height  output  1  sticky: vsync arrived before HEIGHT lines were seen
- err_overrun  output  1  sticky: in_href rose during FLUSH
- frame_cnt  output  CNT_W  count of completed frames; wraps to 0
- busy  output  1  high in ACTIVE or FLUSH

Behaviour:
- Reset values: every output is 0; shadow and active config are 0; FSM is in IDLE.
- Output timing: all out_* signals are registered. In pass-through, out_href, out_vsync and out_de equal the inputs delayed by exactly 1 pclk.
- Shadow config:
  - cfg_wr loads the shadow in any state.
  - Shadow is copied to act_* on the in_vsync falling edge only.
  - cfg_wr on the same cycle as that edge: act_* take the new cfg_* values.
- FSM states: IDLE, VSYNC, ACTIVE, FLUSH.
- IDLE:
  - Pass-through.
  - in_vsync=1 -> VSYNC.
- VSYNC:
  - Pass-through.
  - On the in_vsync falling edge: apply the shadow, clear pix_cnt and line_cnt, go to ACTIVE.
- ACTIVE:
  - Pass-through.
  - pix_cnt increments on each in_href=1 cycle.
  - On each in_href falling edge:
    - if pix_cnt != WIDTH, set err_width;
    - increment line_cnt and reset pix_cnt.
  - When line_cnt reaches HEIGHT on an href fall -> FLUSH.
  - in_vsync=1 before that -> set err_height, go to VSYNC, no flush, no frame_done, frame_cnt unchanged.
- FLUSH:
  - Inputs are not passed through; out_vsync=0.
  - Line sequence, repeated FLUSH_LINES times: HBLANK cycles with out_href=out_de=out_flush=0, then WIDTH cycles with out_href=out_de=out_flush=1.
  - After the last synthetic line:
    - frame_done pulses for 1 cycle;
    - frame_cnt increments, wrapping at 2^CNT_W;
    - go to IDLE.
  - in_href rising edge during FLUSH: set err_overrun; the flush still completes.
  - in_vsync=1 during FLUSH: the flush still completes, the FSM goes to VSYNC instead of IDLE, and frame_done still pulses.
- Counters:
  - pix_cnt width is clog2(WIDTH+1); line_cnt width is clog2(HEIGHT+1).
  - Both saturate and never wrap; an overlong line still sets err_width.
- Error flags:
  - Sticky until err_clr.
  - An error event on the same cycle as err_clr wins: the flag stays 1.
- rst mid-frame: immediately returns to IDLE with all outputs 0. The first frame after reset must start with a full vsync pulse.

Decomposition:
- Package isp_pkg holds:
  - Bayer constants BAYER_RGGB, BAYER_GRBG, BAYER_GBRG, BAYER_BGGR;
  - FSM state encoding ST_IDLE, ST_VSYNC, ST_ACTIVE, ST_FLUSH;
  - a clog2 helper function.
- One natural sub-module, isp_flush_gen: HBLANK/WIDTH/line counters that emit the synthetic href/de/flush and a done pulse. It is started by the controller on entry to FLUSH.

Test Plan:
- Nominal frame, WIDTH=8, HEIGHT=4, FLUSH_LINES=2, HBLANK=4, cfg_wr with bayer=2 mid-frame:
  - inputs appear on out_* 1 cycle later;
  - after the 4th line, 2 synthetic lines of 8 cycles each, each preceded by 4 idle cycles, with out_flush=1;
  - frame_done pulses once; frame_cnt=1;
  - act_bayer changes to 2 only at the next vsync fall.
- Short line of 7 pixels in line 2: err_width=1 and stays 1 after the frame; err_clr clears it to 0.
- vsync after 3 lines: err_height=1, no synthetic lines, no frame_done, frame_cnt unchanged, FSM back in VSYNC.
- in_href rises during the first synthetic line: err_overrun=1; both flush lines still complete; frame_done pulses.
- cfg_wr on the vsync falling-edge cycle with bypass=1: act_bypass=1 for that frame.
- rst asserted mid-FLUSH: out_href, out_flush and busy are 0 the next cycle; frame_cnt=0.
- Wrap check with CNT_W=2: after 4 frames frame_cnt returns to 0.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared types and helpers for the demosaic front-end controller.
package isp_pkg;

    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_GRBG = 2'd1,
        BAYER_GBRG = 2'd2,
        BAYER_BGGR = 2'd3
    } bayer_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VSYNC  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/isp_demosaic_ctrl_if.sv
// Sensor-side and demosaic-side video timing signals of the controller.
interface isp_demosaic_if;
    logic in_href;
    logic in_vsync;
    logic in_de;
    logic out_href;
    logic out_vsync;
    logic out_de;
    logic out_flush;

    modport master (
        output in_href, in_vsync, in_de,
        input  out_href, out_vsync, out_de, out_flush
    );

    modport slave (
        input  in_href, in_vsync, in_de,
        output out_href, out_vsync, out_de, out_flush
    );
endinterface

// File: rtl/isp_flush_gen.sv
// Synthetic line generator: FLUSH_LINES x (HBLANK idle + WIDTH active), then a done pulse.
module isp_flush_gen
    import isp_pkg::*;
#(
    parameter int unsigned WIDTH       = 1280,
    parameter int unsigned HBLANK      = 16,
    parameter int unsigned FLUSH_LINES = 2
) (
    input  logic pclk,
    input  logic rst,
    input  logic start,
    output logic href,
    output logic de,
    output logic flush,
    output logic done
);
    localparam int unsigned CW = clog2(((WIDTH > HBLANK) ? WIDTH : HBLANK) + 1);
    localparam int unsigned LW = clog2(FLUSH_LINES + 1);
    localparam logic [CW-1:0] LAST_PIX   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_BLANK = CW'(HBLANK - 1);
    localparam logic [LW-1:0] LAST_LINE  = LW'(FLUSH_LINES - 1);

    logic          running;
    logic          in_line;
    logic [CW-1:0] cnt;
    logic [LW-1:0] line;

    assign href  = running & in_line;
    assign de    = href;
    assign flush = href;
    assign done  = href && (cnt == LAST_PIX) && (line == LAST_LINE);

    // The start cycle itself is the first blank cycle, so counting resumes at 1.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            in_line <= 1'b0;
            cnt     <= '0;
            line    <= '0;
        end else if (start) begin
            running <= 1'b1;
            in_line <= 1'b0;
            cnt     <= CW'(1);
            line    <= '0;
        end else if (running) begin
            if (!in_line) begin
                if (cnt == LAST_BLANK) begin
                    in_line <= 1'b1;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (cnt == LAST_PIX) begin
                in_line <= 1'b0;
                cnt     <= '0;
                if (line == LAST_LINE) running <= 1'b0;
                else                   line    <= line + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/isp_demosaic_ctrl.sv
// Frame sequencer and frame-boundary config controller in front of the 5x5 demosaic.
module isp_demosaic_ctrl
    import isp_pkg::*;
#(
    parameter int unsigned WIDTH       = 1280,
    parameter int unsigned HEIGHT      = 960,
    parameter int unsigned FLUSH_LINES = 2,
    parameter int unsigned HBLANK      = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [1:0]       cfg_bayer,
    input  logic             cfg_bypass,
    input  logic             cfg_wr,
    input  logic             err_clr,
    isp_demosaic_if.slave    vid,
    output logic [1:0]       act_bayer,
    output logic             act_bypass,
    output logic             frame_done,
    output logic             err_width,
    output logic             err_height,
    output logic             err_overrun,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);
    localparam int unsigned PW = clog2(WIDTH + 1);
    localparam int unsigned LW = clog2(HEIGHT + 1);

    state_t          state, next_state;
    logic            href_d, vsync_d;
    logic [PW-1:0]   pix_cnt;
    logic            pix_long;
    logic [LW-1:0]   line_cnt;
    logic            vsync_seen;
    bayer_t          shadow_bayer;
    logic            shadow_bypass;
    logic            vsync_rise, vsync_fall, href_rise, href_fall;
    logic            last_line, width_bad, frame_end;
    logic            gen_start, gen_href, gen_de, gen_flush, gen_done;

    assign vsync_rise = vid.in_vsync & ~vsync_d;
    assign vsync_fall = ~vid.in_vsync & vsync_d;
    assign href_rise  = vid.in_href & ~href_d;
    assign href_fall  = ~vid.in_href & href_d;
    assign last_line  = (line_cnt == LW'(HEIGHT - 1));
    assign width_bad  = pix_long | (pix_cnt != PW'(WIDTH));
    assign frame_end  = (state == ST_FLUSH) & gen_done;
    assign busy       = (state == ST_ACTIVE) | (state == ST_FLUSH);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        gen_start  = 1'b0;
        case (state)
            ST_IDLE:   if (vsync_rise) next_state = ST_VSYNC;
            ST_VSYNC:  if (vsync_fall) next_state = ST_ACTIVE;
            ST_ACTIVE: begin
                if (href_fall && last_line) begin
                    next_state = ST_FLUSH;
                    gen_start  = 1'b1;
                end else if (vid.in_vsync) begin
                    next_state = ST_VSYNC;
                end
            end
            ST_FLUSH:  if (gen_done) next_state = (vsync_seen | vid.in_vsync) ? ST_VSYNC : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    isp_flush_gen #(
        .WIDTH       (WIDTH),
        .HBLANK      (HBLANK),
        .FLUSH_LINES (FLUSH_LINES)
    ) u_flush_gen (
        .pclk  (pclk),
        .rst   (rst),
        .start (gen_start),
        .href  (gen_href),
        .de    (gen_de),
        .flush (gen_flush),
        .done  (gen_done)
    );

    // vsync_d resets high so a vsync already asserted at reset release is not taken as a frame start.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            href_d        <= 1'b0;
            vsync_d       <= 1'b1;
            pix_cnt       <= '0;
            pix_long      <= 1'b0;
            line_cnt      <= '0;
            vsync_seen    <= 1'b0;
            shadow_bayer  <= BAYER_RGGB;
            shadow_bypass <= 1'b0;
            act_bayer     <= BAYER_RGGB;
            act_bypass    <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
            err_width     <= 1'b0;
            err_height    <= 1'b0;
            err_overrun   <= 1'b0;
            vid.out_href  <= 1'b0;
            vid.out_vsync <= 1'b0;
            vid.out_de    <= 1'b0;
            vid.out_flush <= 1'b0;
        end else begin
            href_d  <= vid.in_href;
            vsync_d <= vid.in_vsync;

            if (cfg_wr) begin
                shadow_bayer  <= bayer_t'(cfg_bayer);
                shadow_bypass <= cfg_bypass;
            end

            if (state == ST_VSYNC && vsync_fall) begin
                act_bayer  <= cfg_wr ? cfg_bayer  : shadow_bayer;
                act_bypass <= cfg_wr ? cfg_bypass : shadow_bypass;
                pix_cnt    <= '0;
                pix_long   <= 1'b0;
                line_cnt   <= '0;
            end else if (state == ST_ACTIVE) begin
                if (href_fall) begin
                    pix_cnt  <= '0;
                    pix_long <= 1'b0;
                    if (line_cnt != LW'(HEIGHT)) line_cnt <= line_cnt + 1'b1;
                end else if (vid.in_href) begin
                    if (pix_cnt == PW'(WIDTH)) pix_long <= 1'b1;
                    if (pix_cnt != '1)         pix_cnt  <= pix_cnt + 1'b1;
                end
            end

            vsync_seen <= (state == ST_FLUSH) & (vsync_seen | vid.in_vsync);

            err_width   <= (err_width   & ~err_clr) | ((state == ST_ACTIVE) & href_fall & width_bad);
            err_height  <= (err_height  & ~err_clr) |
                           ((state == ST_ACTIVE) & vid.in_vsync & ~(href_fall & last_line));
            err_overrun <= (err_overrun & ~err_clr) | ((state == ST_FLUSH) & href_rise);

            frame_done <= frame_end;
            if (frame_end) frame_cnt <= frame_cnt + 1'b1;

            if (state == ST_FLUSH) begin
                vid.out_href  <= gen_href;
                vid.out_vsync <= 1'b0;
                vid.out_de    <= gen_de;
                vid.out_flush <= gen_flush;
            end else begin
                vid.out_href  <= vid.in_href;
                vid.out_vsync <= vid.in_vsync;
                vid.out_de    <= vid.in_de;
                vid.out_flush <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_isp_demosaic_ctrl.sv
// Scoreboard bench for isp_demosaic_ctrl with a small 8x4 frame geometry.
module tb_isp_demosaic_ctrl;
    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned FL = 2;
    localparam int unsigned HB = 4;

    logic       pclk = 1'b0;
    logic       rst;
    logic [1:0] cfg_bayer;
    logic       cfg_bypass;
    logic       cfg_wr;
    logic       err_clr;
    logic [1:0] act_bayer;
    logic       act_bypass;
    logic       frame_done;
    logic       err_width;
    logic       err_height;
    logic       err_overrun;
    logic [1:0] frame_cnt;
    logic       busy;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [4:0]  exp_q[$];

    isp_demosaic_if vif();

    isp_demosaic_ctrl #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .FLUSH_LINES (FL),
        .HBLANK      (HB),
        .CNT_W       (2)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .cfg_bayer   (cfg_bayer),
        .cfg_bypass  (cfg_bypass),
        .cfg_wr      (cfg_wr),
        .err_clr     (err_clr),
        .vid         (vif),
        .act_bayer   (act_bayer),
        .act_bypass  (act_bypass),
        .frame_done  (frame_done),
        .err_width   (err_width),
        .err_height  (err_height),
        .err_overrun (err_overrun),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected word: {href, vsync, de, flush, frame_done} registered after this edge.
    task automatic tick(input logic h, input logic v, input logic d, input logic [4:0] want);
        logic [4:0] got;
        vif.in_href  = h;
        vif.in_vsync = v;
        vif.in_de    = d;
        exp_q.push_back(want);
        @(posedge pclk);
        #1;
        got = {vif.out_href, vif.out_vsync, vif.out_de, vif.out_flush, frame_done};
        check("video", {27'd0, got}, {27'd0, exp_q.pop_front()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 5'b00000);
    endtask

    task automatic vsync_high(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 5'b01000);
    endtask

    task automatic send_line(input int len);
        for (int i = 0; i < len; i++) tick(1'b1, 1'b0, 1'b1, 5'b10100);
    endtask

    // Begins on the cycle the last real href falls; stop_at truncates the sequence.
    task automatic flush_seq(input bit ovr, input int stop_at);
        int   n;
        logic h;
        n = 0;
        for (int l = 0; l < FL; l++) begin
            for (int b = 0; b < HB; b++) begin
                if (n == stop_at) return;
                tick(1'b0, 1'b0, 1'b0, 5'b00000);
                n++;
            end
            for (int p = 0; p < W; p++) begin
                if (n == stop_at) return;
                h = ovr && (l == 0) && (p >= 2) && (p < 5);
                tick(h, 1'b0, h, {4'b1011, (l == FL - 1) && (p == W - 1)});
                n++;
            end
        end
    endtask

    task automatic frame_start(input bit wr_on_fall);
        vsync_high(3);
        cfg_wr = wr_on_fall;
        tick(1'b0, 1'b0, 1'b0, 5'b00000);
        cfg_wr = 1'b0;
        idle(2);
    endtask

    task automatic frame_body(input int short_idx, input int short_len, input bit ovr, input int stop_at);
        for (int ln = 0; ln < H; ln++) begin
            send_line((ln == short_idx) ? short_len : W);
            if (ln < H - 1) idle(3);
            else            flush_seq(ovr, stop_at);
        end
    endtask

    initial begin
        rst          = 1'b1;
        cfg_bayer    = 2'd0;
        cfg_bypass   = 1'b0;
        cfg_wr       = 1'b0;
        err_clr      = 1'b0;
        vif.in_href  = 1'b0;
        vif.in_vsync = 1'b0;
        vif.in_de    = 1'b0;
        repeat (3) @(posedge pclk);
        #1 rst = 1'b0;
        check("rst_video", {27'd0, vif.out_href, vif.out_vsync, vif.out_de, vif.out_flush, frame_done}, 32'd0);
        check("rst_act", {29'd0, act_bayer, act_bypass}, 32'd0);
        check("rst_err", {29'd0, err_width, err_height, err_overrun}, 32'd0);
        check("rst_cnt", {30'd0, frame_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        idle(2);

        // Nominal frame with a config write in the middle of line 1
        frame_start(1'b0);
        send_line(W);
        idle(3);
        cfg_bayer = 2'd2;
        cfg_wr    = 1'b1;
        tick(1'b1, 1'b0, 1'b1, 5'b10100);
        cfg_wr    = 1'b0;
        check("a_act_hold", {30'd0, act_bayer}, 32'd0);
        check("a_busy", {31'd0, busy}, 32'd1);
        send_line(W - 1);
        idle(3);
        send_line(W);
        idle(3);
        send_line(W);
        flush_seq(1'b0, -1);
        idle(3);
        check("a_cnt", {30'd0, frame_cnt}, 32'd1);
        check("a_act_end", {30'd0, act_bayer}, 32'd0);
        check("a_err", {29'd0, err_width, err_height, err_overrun}, 32'd0);
        check("a_idle_busy", {31'd0, busy}, 32'd0);

        // Short line 1 of 7 pixels
        frame_start(1'b0);
        check("b_act_new", {30'd0, act_bayer}, 32'd2);
        frame_body(1, W - 1, 1'b0, -1);
        idle(3);
        check("b_errw", {31'd0, err_width}, 32'd1);
        check("b_cnt", {30'd0, frame_cnt}, 32'd2);
        idle(5);
        check("b_errw_sticky", {31'd0, err_width}, 32'd1);
        err_clr = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 5'b00000);
        err_clr = 1'b0;
        check("b_errw_clr", {31'd0, err_width}, 32'd0);

        // vsync after three lines: no flush, counter unchanged
        frame_start(1'b0);
        for (int ln = 0; ln < 3; ln++) begin
            send_line(W);
            idle(3);
        end
        vsync_high(1);
        check("c_errh", {31'd0, err_height}, 32'd1);
        check("c_busy", {31'd0, busy}, 32'd0);
        check("c_cnt", {30'd0, frame_cnt}, 32'd2);
        vsync_high(2);
        tick(1'b0, 1'b0, 1'b0, 5'b00000);
        idle(2);

        // href rises during the first synthetic line
        frame_start(1'b0);
        frame_body(-1, W, 1'b1, -1);
        idle(3);
        check("d_overrun", {31'd0, err_overrun}, 32'd1);
        check("d_cnt", {30'd0, frame_cnt}, 32'd3);

        // Config write on the vsync falling-edge cycle; counter wraps after this frame
        cfg_bayer  = 2'd2;
        cfg_bypass = 1'b1;
        frame_start(1'b1);
        check("e_bypass", {31'd0, act_bypass}, 32'd1);
        check("e_bayer", {30'd0, act_bayer}, 32'd2);
        frame_body(-1, W, 1'b0, -1);
        idle(3);
        check("e_cnt_wrap", {30'd0, frame_cnt}, 32'd0);

        frame_start(1'b0);
        frame_body(-1, W, 1'b0, -1);
        idle(3);
        check("f_cnt", {30'd0, frame_cnt}, 32'd1);
        check("f_bypass", {31'd0, act_bypass}, 32'd1);

        // Reset in the middle of the flush, vsync held high across reset release
        frame_start(1'b0);
        frame_body(-1, W, 1'b0, HB + 3);
        rst          = 1'b1;
        vif.in_href  = 1'b0;
        vif.in_de    = 1'b0;
        vif.in_vsync = 1'b1;
        @(posedge pclk);
        #1;
        check("g_href", {31'd0, vif.out_href}, 32'd0);
        check("g_flush", {31'd0, vif.out_flush}, 32'd0);
        check("g_busy", {31'd0, busy}, 32'd0);
        check("g_cnt", {30'd0, frame_cnt}, 32'd0);
        check("g_err", {29'd0, err_width, err_height, err_overrun}, 32'd0);
        check("g_act", {29'd0, act_bayer, act_bypass}, 32'd0);
        rst = 1'b0;
        vsync_high(2);
        check("g_no_start", {31'd0, busy}, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 5'b00000);
        idle(2);
        send_line(W);
        idle(2);
        check("g_still_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
